// File: rtl/bin_to_bcd_display_if.sv
// Handshake and display bundle between a binary producer and the BCD converter.
// master = value producer / display consumer, slave = bin_to_bcd_display.
interface bin_to_bcd_display_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic [15:0]       HEX;
    logic              OUT_VALID;
    logic              OVERFLOW;
    logic              BUSY;

    modport master (
        output IN_DATA, IN_VALID,
        input  IN_READY, HEX, OUT_VALID, OVERFLOW, BUSY
    );

    modport slave (
        input  IN_DATA, IN_VALID,
        output IN_READY, HEX, OUT_VALID, OVERFLOW, BUSY
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Bit-serial double-dabble binary-to-BCD converter feeding a 4-digit display driver.
// Optional macro BCD_SATURATE_EN: out-of-range values display as 9999 instead of value mod 10000.
module bin_to_bcd_display #(
    parameter int DATA_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    bin_to_bcd_display_if.slave  bus
);

    if (DATA_W < 4 || DATA_W > 16) begin : g_bad_width
        $error("bin_to_bcd_display: DATA_W must be in 4..16");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [19:0]       acc_reg;
    logic [DATA_W-1:0] sr_reg;
    logic [4:0]        cnt_reg;
    logic [15:0]       hex_reg;
    logic              out_valid_reg;
    logic              overflow_reg;
    logic              busy_reg;

    logic [18:0]       acc_corr_next;
    logic              fifth_nz_next;
    logic [15:0]       hex_next;

    // The fifth digit is at most 3 before the final shift, so it never needs correcting;
    // only its low three bits survive the shift.
    assign acc_corr_next[18:16] = acc_reg[18:16];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_corr
            assign acc_corr_next[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5)
                                            ? acc_reg[gi*4 +: 4] + 4'd3
                                            : acc_reg[gi*4 +: 4];
        end
    endgenerate

    generate
        if (DATA_W > 13) begin : g_ovf
            assign fifth_nz_next = |acc_reg[19:16];
        end else begin : g_no_ovf
            assign fifth_nz_next = 1'b0;
        end
    endgenerate

`ifdef BCD_SATURATE_EN
    assign hex_next = fifth_nz_next ? 16'h9999 : acc_reg[15:0];
`else
    assign hex_next = acc_reg[15:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            sr_reg        <= '0;
            cnt_reg       <= '0;
            hex_reg       <= 16'h0000;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        sr_reg    <= bus.IN_DATA;
                        acc_reg   <= '0;
                        cnt_reg   <= 5'(DATA_W);
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg <= {acc_corr_next, sr_reg[DATA_W-1]};
                    sr_reg  <= {sr_reg[DATA_W-2:0], 1'b0};
                    cnt_reg <= cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // HEX only ever changes here, so the display never sees partial sums.
                    hex_reg       <= hex_next;
                    overflow_reg  <= fifth_nz_next;
                    out_valid_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.IN_READY  = (state_reg == IDLE) && !RST;
    assign bus.HEX       = hex_reg;
    assign bus.OUT_VALID = out_valid_reg;
    assign bus.OVERFLOW  = overflow_reg;
    assign bus.BUSY      = busy_reg;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display against a decimal-arithmetic reference model.
module tb_bin_to_bcd_display;
    localparam int DATA_W = 16;
    localparam int LAT    = DATA_W + 1;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bin_to_bcd_display_if #(.DATA_W(DATA_W)) bus ();

    bin_to_bcd_display #(.DATA_W(DATA_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [15:0] model_hex(input int v);
        int m;
        logic [15:0] h;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        m = v % 10000;
        h[15:12] = 4'(m / 1000);
        h[11:8]  = 4'((m / 100) % 10);
        h[7:4]   = 4'((m / 10) % 10);
        h[3:0]   = 4'(m % 10);
        return h;
    endfunction

    function automatic logic model_ov(input int v);
        return v > 9999;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Present v until accepted; acc_cyc is the cycle count right after the accepting edge.
    task automatic send(input int v, output int acc_cyc, output bit ok);
        bit rdy;
        ok = 1'b0;
        acc_cyc = 0;
        bus.IN_DATA  = 16'(v);
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = bus.IN_READY;
            tick();
            if (rdy) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output int out_cyc, output bit ok);
        ok = 1'b0;
        out_cyc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (bus.OUT_VALID) begin
                ok = 1'b1;
                out_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = '0;
        tick(); tick(); tick();
        tests_run++;
        if (bus.IN_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_low: got %b expected 0", bus.IN_READY);
        end
        RST = 1'b0;
        #1;
        tests_run++;
        if (bus.HEX !== 16'h0000 || bus.OUT_VALID !== 1'b0 || bus.OVERFLOW !== 1'b0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got hex=%h ov=%b ovf=%b busy=%b expected 0000/0/0/0",
                     bus.HEX, bus.OUT_VALID, bus.OVERFLOW, bus.BUSY);
        end
        tests_run++;
        if (bus.IN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_high: got %b expected 1", bus.IN_READY);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic;
        int a, low_cnt, seen;
        bit ok;
        send(1234, a, ok);
        low_cnt = 0;
        seen = -1;
        for (int i = 0; i < 30 && seen < 0; i++) begin
            if (bus.IN_READY === 1'b0) low_cnt++;
            else seen = cyc;
            if (seen < 0) tick();
        end
        tests_run++;
        if (!ok || low_cnt != LAT) begin
            tests_failed++;
            $display("FAIL basic_ready_low_cycles: got %0d expected %0d", low_cnt, LAT);
        end
        tests_run++;
        if (bus.OUT_VALID !== 1'b1 || seen - a != LAT) begin
            tests_failed++;
            $display("FAIL basic_latency: got out_valid=%b at +%0d expected 1 at +%0d", bus.OUT_VALID, seen - a, LAT);
        end
        tests_run++;
        if (bus.HEX !== 16'h1234 || bus.OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got hex=%h ovf=%b expected 1234/0", bus.HEX, bus.OVERFLOW);
        end
        $display("[TB] conv 1234 -> hex %h ovf %b", bus.HEX, bus.OVERFLOW);
        tick();
        tests_run++;
        if (bus.OUT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pulse_width: got %b expected 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_zero_9999;
        int a, oc;
        bit ok, ok2, held;
        send(0, a, ok);
        wait_out(oc, ok2);
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== 16'h0000 || bus.OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_result: got hex=%h ovf=%b expected 0000/0", bus.HEX, bus.OVERFLOW);
        end
        $display("[TB] conv 0 -> hex %h ovf %b", bus.HEX, bus.OVERFLOW);
        tick(); tick();
        send(9999, a, ok);
        held = 1'b1;
        ok2 = 1'b0;
        for (int i = 0; i < 40 && !ok2; i++) begin
            if (bus.HEX !== 16'h0000) held = 1'b0;
            tick();
            if (bus.OUT_VALID) ok2 = 1'b1;
        end
        tests_run++;
        if (!held) begin
            tests_failed++;
            $display("FAIL hex_hold: got hex change before out_valid expected held 0000");
        end
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== 16'h9999 || bus.OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL max_4digit_result: got hex=%h ovf=%b expected 9999/0", bus.HEX, bus.OVERFLOW);
        end
        $display("[TB] conv 9999 -> hex %h ovf %b", bus.HEX, bus.OVERFLOW);
    endtask

    task automatic test_overflow;
        int a, oc;
        bit ok, ok2;
        send(12345, a, ok);
        wait_out(oc, ok2);
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== model_hex(12345) || bus.OVERFLOW !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_result: got hex=%h ovf=%b expected %h/1", bus.HEX, bus.OVERFLOW, model_hex(12345));
        end
        $display("[TB] conv 12345 -> hex %h ovf %b", bus.HEX, bus.OVERFLOW);
        send(42, a, ok);
        wait_out(oc, ok2);
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== 16'h0042 || bus.OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: got hex=%h ovf=%b expected 0042/0", bus.HEX, bus.OVERFLOW);
        end
        $display("[TB] conv 42 -> hex %h ovf %b", bus.HEX, bus.OVERFLOW);
    endtask

    task automatic test_back_to_back;
        int acc_c[2];
        logic [15:0] res_hex[2];
        logic res_ov[2];
        int nacc, nres;
        bit rdy;
        nacc = 0;
        nres = 0;
        bus.IN_DATA  = 16'd7;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 80 && nres < 2; i++) begin
            rdy = bus.IN_READY;
            tick();
            if (rdy && bus.IN_VALID && nacc < 2) begin
                acc_c[nacc] = cyc;
                nacc++;
                if (nacc == 1) bus.IN_DATA = 16'hFFFF;
                else bus.IN_VALID = 1'b0;
            end
            if (bus.OUT_VALID && nres < 2) begin
                res_hex[nres] = bus.HEX;
                res_ov[nres]  = bus.OVERFLOW;
                $display("[TB] b2b result %0d -> hex %h ovf %b", nres, bus.HEX, bus.OVERFLOW);
                nres++;
            end
        end
        bus.IN_VALID = 1'b0;
        tests_run++;
        if (nacc != 2 || nres != 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d accepts %0d results expected 2/2", nacc, nres);
        end else begin
            tests_run++;
            if (acc_c[1] - acc_c[0] != DATA_W + 2) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d expected %0d", acc_c[1] - acc_c[0], DATA_W + 2);
            end
            tests_run++;
            if (res_hex[0] !== 16'h0007 || res_ov[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_first: got hex=%h ovf=%b expected 0007/0", res_hex[0], res_ov[0]);
            end
            tests_run++;
            if (res_hex[1] !== model_hex(65535) || res_ov[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_second: got hex=%h ovf=%b expected %h/1", res_hex[1], res_ov[1], model_hex(65535));
            end
        end
    endtask

    task automatic test_reset_mid;
        int a, oc;
        bit ok, ok2, spurious;
        send(4321, a, ok);
        for (int i = 0; i < 8; i++) tick();
        RST = 1'b1;
        #1;
        tests_run++;
        if (bus.IN_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_ready_during_rst: got %b expected 0", bus.IN_READY);
        end
        tick();
        RST = 1'b0;
        #1;
        tests_run++;
        if (!ok || bus.HEX !== 16'h0000 || bus.BUSY !== 1'b0 || bus.OVERFLOW !== 1'b0 || bus.IN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: got hex=%h busy=%b ovf=%b rdy=%b expected 0000/0/0/1",
                     bus.HEX, bus.BUSY, bus.OVERFLOW, bus.IN_READY);
        end
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.OUT_VALID) spurious = 1'b1;
        end
        tests_run++;
        if (spurious) begin
            tests_failed++;
            $display("FAIL midreset_no_out_valid: got out_valid=1 expected none");
        end
        send(55, a, ok);
        wait_out(oc, ok2);
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== 16'h0055) begin
            tests_failed++;
            $display("FAIL midreset_recover: got hex=%h expected 0055", bus.HEX);
        end
        $display("[TB] conv 55 after reset -> hex %h", bus.HEX);
    endtask

    task automatic test_busy_ignore;
        int a, oc, v0;
        bit ok, ok2, accepted;
        v0 = int'($urandom_range(0, 65535));
        send(v0, a, ok);
        accepted = 1'b0;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.IN_DATA = 16'($urandom);
            #1;
            if (bus.IN_READY) accepted = 1'b1;
            tick();
        end
        bus.IN_VALID = 1'b0;
        tests_run++;
        if (accepted) begin
            tests_failed++;
            $display("FAIL busy_ready: got ready=1 while busy expected 0");
        end
        wait_out(oc, ok2);
        tests_run++;
        if (!ok || !ok2 || bus.HEX !== model_hex(v0) || bus.OVERFLOW !== model_ov(v0)) begin
            tests_failed++;
            $display("FAIL busy_result: got hex=%h ovf=%b expected %h/%b for %0d",
                     bus.HEX, bus.OVERFLOW, model_hex(v0), model_ov(v0), v0);
        end
        $display("[TB] conv %0d (busy noise) -> hex %h ovf %b", v0, bus.HEX, bus.OVERFLOW);
        tick();
        tests_run++;
        if (bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_no_queue: got busy=%b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_random;
        int a, oc, v, gap;
        bit ok, ok2;
        for (int n = 0; n < 20; n++) begin
            v = (n % 3 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            send(v, a, ok);
            wait_out(oc, ok2);
            tests_run++;
            if (!ok || !ok2 || oc - a != LAT) begin
                tests_failed++;
                $display("FAIL rand_latency: got %0d expected %0d for %0d", oc - a, LAT, v);
            end
            tests_run++;
            if (bus.HEX !== model_hex(v)) begin
                tests_failed++;
                $display("FAIL rand_hex: got %h expected %h for %0d", bus.HEX, model_hex(v), v);
            end
            tests_run++;
            if (bus.OVERFLOW !== model_ov(v)) begin
                tests_failed++;
                $display("FAIL rand_ovf: got %b expected %b for %0d", bus.OVERFLOW, model_ov(v), v);
            end
            $display("[TB] conv %0d -> hex %h ovf %b", v, bus.HEX, bus.OVERFLOW);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_9999();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle.
- Sits directly upstream of the four-digit seven-segment driver.
- Accepts an unsigned binary word over a valid/ready handshake and drives a held 16-bit, four-nibble BCD word onto the driver's HEX input.
- Lets machine values (cons counters, addresses, cycle counts) display in decimal.

Parameters:
- DATA_W, 16, width of the binary input. Legal range 4..16; any other value is a compile-time error.

Ports:
- CLK  input  1  system clock, 100 MHz
- RST  input  1  synchronous active-high reset
- IN_DATA  input  DATA_W  unsigned binary value to convert
- IN_VALID  input  1  IN_DATA is valid this cycle
- IN_READY  output  1  block can accept a value this cycle
- HEX  output  16  BCD result; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
- OUT_VALID  output  1  one-cycle pulse when HEX has just been updated
- OVERFLOW  output  1  last converted value exceeded 9999; held until next update
- BUSY  output  1  conversion in progress

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, RST, sampled on the CLK rising edge.
- Reset values: HEX=16'h0000, OUT_VALID=0, OVERFLOW=0, BUSY=0, state=IDLE, shift count=0.
- IN_READY is combinational: (state==IDLE) && !RST. It is 0 during any cycle with RST high.
- Handshake: a transfer occurs on a rising edge where IN_VALID && IN_READY. IN_DATA is captured only then. IN_VALID while not ready is ignored and not queued; the producer must hold it.
- Internal registers:
  - 20-bit BCD accumulator, five digits; the fifth digit is used for overflow detection.
  - DATA_W-bit binary shift register.
  - 5-bit bit counter.
- State machine:
  - IDLE: on transfer, load the shift register with IN_DATA, clear the accumulator, set the counter to DATA_W, go to SHIFT. BUSY=0.
  - SHIFT: each cycle:
    - Add 3 to every accumulator nibble that is >=5. Compute this combinationally from the current value.
    - Shift {accumulator, shift register} left by 1; the shift register MSB enters accumulator bit 0.
    - Decrement the counter.
    - Leave SHIFT for DONE when the counter reaches 0 after this cycle, i.e. after exactly DATA_W shift cycles.
    - BUSY=1.
  - DONE: register HEX from the accumulator (see Optional Feature for overflow handling). Set OVERFLOW = (fifth digit != 0). Pulse OUT_VALID for exactly this one cycle, then go to IDLE. BUSY=1.
- Latency: for a transfer at edge T, HEX/OUT_VALID/OVERFLOW update at edge T+DATA_W+1. For DATA_W=16 that is 17 cycles.
- Throughput: IN_READY returns high the cycle after OUT_VALID. With IN_VALID held high, the minimum accept-to-accept spacing is DATA_W+2 cycles.
- HEX holds its last value between conversions; it never shows intermediate accumulator values, so the display stays glitch-free.
- Simultaneous events: RST high overrides any transfer or state action on the same edge.
- Reset mid-conversion: the conversion is aborted and discarded. Outputs go to their reset values, and no OUT_VALID is emitted for the aborted value.
- Width rules:
  - All nibble correction is done on 4-bit values; a corrected nibble never exceeds 4'hC before the shift.
  - IN_DATA is zero-extended internally to 16 bits, so the fifth digit can only be 0..6.
  - For DATA_W<=13 (max 8191), OVERFLOW is constant 0.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: when the fifth digit is nonzero, HEX is forced to 16'h9999 in DONE, and OVERFLOW=1.
- Not defined: HEX is the low four BCD digits (value mod 10000), and OVERFLOW=1. Example: 12345 displays 2345.
- OVERFLOW behaviour is identical in both builds.

Test Plan:
- Reset, then IN_DATA=1234 with IN_VALID pulsed one cycle -> IN_READY low for 17 cycles; HEX=16'h1234 with a one-cycle OUT_VALID at accept+17; OVERFLOW=0.
- Convert 0, then 9999 -> HEX=16'h0000, then 16'h9999; OVERFLOW=0 for both; HEX unchanged between the two OUT_VALID pulses.
- Convert 12345 -> OVERFLOW=1; HEX=16'h2345 without BCD_SATURATE_EN, HEX=16'h9999 with it. Then convert 42 -> HEX=16'h0042, OVERFLOW=0.
- IN_VALID held high with IN_DATA=7, then 65535 -> second accept exactly 18 cycles after the first; results 16'h0007 then 16'h5535 (or 16'h9999 with the macro); OVERFLOW=1 on the second.
- Assert RST for one cycle at accept+8 during conversion of 4321 -> no OUT_VALID; HEX=16'h0000; IN_READY high the cycle after RST deasserts; a new conversion of 55 yields 16'h0055.
- IN_VALID asserted while BUSY, with IN_DATA changing each cycle -> none accepted; result reflects only the value present at the IN_READY&&IN_VALID edge.
